vgacon_term_ctrl: RTL and testbench

Terminal-style write controller for the VGA console text buffer. It accepts a stream of 8-bit characters over a valid/ready handshake and turns them into single-cell writes against the character/colour buffer. It owns the cursor and handles line wrap, control characters, full-screen clear and hardware scroll by row copy. It sits between the TinyQV register interface (or a UART RX path) and the text buffer, and replaces direct per-cell addressing by software.

---
 rtl/vgacon_term_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_vgacon_term_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgacon_term_ctrl.sv
// vgacon_term_ctrl
//   Terminal-style write controller for the VGA console text buffer.
//   Accepts 8-bit characters over a valid/ready handshake and turns them
//   into single-cell writes against the {colour, code} text buffer. It owns
//   the cursor and handles line wrap, CR/LF/BS/FF, full-screen clear and
//   hardware scroll by copying each row up by one.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      character offered
//   in_ready      character can be accepted this cycle (IDLE only)
//   in_char       character code
//   in_color      colour index stored with printable characters
//   buf_we        registered buffer write strobe
//   buf_addr      registered buffer write address
//   buf_wdata     registered write data {color[1:0], code[6:0]}
//   buf_raddr     buffer read address (used during scroll copy)
//   buf_rdata     buffer read data, combinational from buf_raddr
//   cur_row       cursor row
//   cur_col       cursor column
//   busy          inverse of in_ready

module vgacon_term_ctrl #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 10,
    parameter int ADDR_W   = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_char,
    input  logic [1:0]                  in_color,
    output logic                        buf_we,
    output logic [ADDR_W-1:0]           buf_addr,
    output logic [8:0]                  buf_wdata,
    output logic [ADDR_W-1:0]           buf_raddr,
    input  logic [8:0]                  buf_rdata,
    output logic [$clog2(NUM_ROWS)-1:0] cur_row,
    output logic [$clog2(NUM_COLS)-1:0] cur_col,
    output logic                        busy
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);

    localparam logic [8:0]        BLANK         = 9'h020;
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] COPY_LAST     = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_CLR_LAST  = ADDR_W'(NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL_COPY,
        SCROLL_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q,   cnt_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [COL_W-1:0]   col_q,   col_d;
    logic               we_q,    we_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [8:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]  cursor_addr;
    logic               printable;

    assign cursor_addr = ADDR_W'(32'(row_q) * NUM_COLS + 32'(col_q));
    assign printable   = (in_char >= 8'h20) && (in_char <= 8'h7E);

    // Read runs one row ahead of the write, so copy never reads a cell it
    // has already overwritten.
    assign buf_raddr = cnt_q + ADDR_W'(NUM_COLS);

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign buf_we    = we_q;
    assign buf_addr  = addr_q;
    assign buf_wdata = wdata_q;
    assign cur_row   = row_q;
    assign cur_col   = col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        we_d    = 1'b1;
                        addr_d  = cursor_addr;
                        wdata_d = {in_color, in_char[6:0]};
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                state_d = SCROLL_COPY;
                                cnt_d   = '0;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        case (in_char)
                            8'h0A: begin
                                col_d = '0;
                                if (row_q == ROW_LAST) begin
                                    state_d = SCROLL_COPY;
                                    cnt_d   = '0;
                                end else begin
                                    row_d = row_q + 1'b1;
                                end
                            end
                            8'h0D: col_d = '0;
                            8'h08: begin
                                // No retreat past column 0.
                                if (col_q != '0) begin
                                    col_d   = col_q - 1'b1;
                                    we_d    = 1'b1;
                                    addr_d  = cursor_addr - 1'b1;
                                    wdata_d = BLANK;
                                end
                            end
                            8'h0C: begin
                                row_d   = '0;
                                col_d   = '0;
                                state_d = CLEAR;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            CLEAR: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = BLANK;
                if (cnt_q == LAST_CELL) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SCROLL_COPY: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = buf_rdata;
                if (cnt_q == COPY_LAST) begin
                    cnt_d   = '0;
                    state_d = SCROLL_CLEAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SCROLL_CLEAR: begin
                we_d    = 1'b1;
                addr_d  = LAST_ROW_BASE + cnt_q;
                wdata_d = BLANK;
                if (cnt_q == ROW_CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_vgacon_term_ctrl.sv
// Testbench for vgacon_term_ctrl. A screen-level reference model predicts
// every buffer write (address, data, cycle) into a scoreboard queue; a
// monitor on the falling edge pops and compares each DUT write and also
// checks in_ready/busy and the cursor every cycle.

module tb_vgacon_term_ctrl;

    localparam int NR    = 3;
    localparam int NC    = 10;
    localparam int CELLS = NR * NC;
    localparam int AW    = 5;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_char = 8'h00;
    logic [1:0]    in_color = 2'b00;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [8:0]    buf_wdata;
    logic [AW-1:0] buf_raddr;
    logic [8:0]    buf_rdata;
    logic [1:0]    cur_row;
    logic [3:0]    cur_col;
    logic          busy;

    always #5 clk = ~clk;

    vgacon_term_ctrl #(
        .NUM_ROWS(NR),
        .NUM_COLS(NC),
        .ADDR_W  (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .in_color (in_color),
        .buf_we   (buf_we),
        .buf_addr (buf_addr),
        .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr),
        .buf_rdata(buf_rdata),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .busy     (busy)
    );

    // The text buffer the controller drives.
    logic [8:0] mem [0:31];
    always @(posedge clk) if (buf_we) mem[buf_addr] <= buf_wdata;
    assign buf_rdata = mem[buf_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int at;
    } wr_t;

    wr_t exp_q[$];
    int  scr[CELLS];
    int  ref_row = 0;
    int  ref_col = 0;
    int  exp_ready_cyc = NEVER;
    int  n_cmp = 0;
    int  n_bad = 0;

    // ---------------- reference model ----------------
    function automatic void push_wr(int a, int d, int at);
        exp_q.push_back('{addr: a, data: d, at: at});
    endfunction

    function automatic void do_clear(int start);
        for (int k = 0; k < CELLS; k++) begin
            scr[k] = 'h20;
            push_wr(k, 'h20, start + k);
        end
        exp_ready_cyc = start + CELLS - 1;
    endfunction

    // Screen shifts up one row, last row blanked; sequence starts after e.
    function automatic void do_scroll(int e);
        for (int k = 0; k < CELLS - NC; k++) begin
            scr[k] = scr[k + NC];
            push_wr(k, scr[k], e + 1 + k);
        end
        for (int k = CELLS - NC; k < CELLS; k++) begin
            scr[k] = 'h20;
            push_wr(k, 'h20, e + 1 + k);
        end
        exp_ready_cyc = e + CELLS;
    endfunction

    function automatic void newline(int e);
        ref_col = 0;
        if (ref_row == NR - 1) do_scroll(e);
        else ref_row++;
    endfunction

    function automatic void model_accept(int ch, int color, int e);
        int a;
        int d;
        if (ch >= 'h20 && ch <= 'h7E) begin
            a = ref_row * NC + ref_col;
            d = color * 128 + (ch % 128);
            scr[a] = d;
            push_wr(a, d, e);
            if (ref_col == NC - 1) newline(e);
            else ref_col++;
        end else if (ch == 'h0A) begin
            newline(e);
        end else if (ch == 'h0D) begin
            ref_col = 0;
        end else if (ch == 'h08) begin
            if (ref_col > 0) begin
                ref_col--;
                a = ref_row * NC + ref_col;
                scr[a] = 'h20;
                push_wr(a, 'h20, e);
            end
        end else if (ch == 'h0C) begin
            ref_row = 0;
            ref_col = 0;
            do_clear(e + 1);
        end
    endfunction

    // ---------------- monitor ----------------
    wr_t mon_w;
    bit  mon_er;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_er = (cyc >= exp_ready_cyc);
            n_cmp++;
            if (in_ready !== mon_er || busy !== !mon_er) begin
                n_bad++;
                $display("FAIL ready cyc=%0d in_ready=%b busy=%b expected in_ready=%b", cyc, in_ready, busy, mon_er);
            end
            n_cmp++;
            if (int'(cur_row) != ref_row || int'(cur_col) != ref_col) begin
                n_bad++;
                $display("FAIL cursor cyc=%0d got (%0d,%0d) expected (%0d,%0d)", cyc, cur_row, cur_col, ref_row, ref_col);
            end
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                mon_w = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_write cyc=%0d got none expected addr=%0d data=%h at=%0d", cyc, mon_w.addr, mon_w.data, mon_w.at);
            end
            if (buf_we) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%h expected no write", cyc, buf_addr, buf_wdata);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (int'(buf_addr) != mon_w.addr || int'(buf_wdata) != mon_w.data || cyc != mon_w.at) begin
                        n_bad++;
                        $display("FAIL write got addr=%0d data=%h at=%0d expected addr=%0d data=%h at=%0d",
                                 buf_addr, buf_wdata, cyc, mon_w.addr, mon_w.data, mon_w.at);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", int'(buf_we), 0);
        chk("rst_addr", int'(buf_addr), 0);
        chk("rst_wdata", int'(buf_wdata), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cursor", int'(cur_row) * 16 + int'(cur_col), 0);
    endtask

    // Leaves in_valid high after the handshake so back-to-back sends keep it asserted.
    task automatic send(input int ch, input int color);
        int tries;
        int e;
        tries = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 8'(ch);
        in_color = 2'(color);
        while (!in_ready && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout char=%h got in_ready=0 expected 1", ch);
            in_valid = 1'b0;
            return;
        end
        e = cyc + 1;
        @(posedge clk);
        model_accept(ch, color, e);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((cyc < exp_ready_cyc || exp_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout got pending=%0d expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic check_mem();
        for (int i = 0; i < CELLS; i++) begin
            n_cmp++;
            if (int'(mem[i]) != scr[i]) begin
                n_bad++;
                $display("FAIL buffer[%0d] got %h expected %h", i, mem[i], scr[i]);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ref_row = 0;
        ref_col = 0;
        do_clear(cyc + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int ch;
        // Reset and initial clear.
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs();
        release_reset();
        wait_idle();
        check_mem();

        // Single printable.
        send('h41, 2);
        wait_idle();
        chk("A_cell", int'(mem[0]), 'h141);

        // Fill row 0 from home.
        send('h0C, 0);
        for (int i = 0; i < NC; i++) send('h30 + i, i % 4);
        wait_idle();
        check_mem();

        // Fill the screen to (2,9), then a wrapping printable triggers a scroll.
        send('h0C, 0);
        for (int i = 0; i < CELLS - 1; i++) send($urandom_range('h21, 'h7E), $urandom_range(0, 3));
        send('h5A, 1);
        wait_idle();
        chk("Z_scrolled", int'(mem[19]), 'h0DA);
        check_mem();

        // Backspace at column 0, then after one character.
        send('h0C, 0);
        send('h08, 0);
        send('h78, 3);
        send('h08, 0);
        wait_idle();
        check_mem();

        // FF and Q back to back with in_valid held through the clear.
        send('h0C, 0);
        send('h51, 1);
        wait_idle();
        check_mem();

        // Reset in the middle of a clear.
        send('h0C, 0);
        gap(8);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_ready_cyc = NEVER;
        ref_row = 0;
        ref_col = 0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        release_reset();
        wait_idle();
        check_mem();

        // Randomised character stream.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      ch = $urandom_range('h20, 'h7E);
            else if (r < 78) ch = 'h0A;
            else if (r < 84) ch = 'h0D;
            else if (r < 92) ch = 'h08;
            else if (r < 94) ch = 'h0C;
            else             ch = $urandom_range(0, 255);
            send(ch, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end
        wait_idle();
        check_mem();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
